// File: rtl/trace_grid_recorder_pkg.sv
// Purpose: shared state type, grid constants and default geometry for the trace grid recorder.
// Latency: n/a, declarations only.
// Backpressure: n/a.
//
// Contents: trace_state_e (IDLE/TRACING/DONE), 4x4 grid constants, cursor widths,
// default trace-area geometry and the cell index packing helper.
package trace_pkg;

  // Grid geometry: fixed 4x4 grid, 16 cells, 4-bit cell index.
  localparam int GRID_DIM   = 4;
  localparam int NUM_CELLS  = GRID_DIM * GRID_DIM;
  localparam int CELL_IDX_W = 4;

  // Visit order: one nibble per registered cell; the length runs 0..16.
  localparam int SEQ_W      = NUM_CELLS * CELL_IDX_W;
  localparam int SEQ_LEN_W  = 5;

  // Cursor coordinate widths.
  localparam int ROW_W      = 9;
  localparam int COL_W      = 10;

  // Default trace-area geometry and timing, in pixels and frames.
  localparam int DEF_TRACE_ROW0     = 40;
  localparam int DEF_TRACE_COL0     = 120;
  localparam int DEF_CELL_SIZE      = 100;
  localparam int DEF_DWELL_FRAMES   = 4;
  localparam int DEF_TIMEOUT_FRAMES = 180;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACING = 2'd1,
    DONE    = 2'd2
  } trace_state_e;

  // Cell index is row-major: row_cell*4 + col_cell.
  function automatic logic [CELL_IDX_W-1:0] cell_index(input logic [1:0] row_cell,
                                                       input logic [1:0] col_cell);
    return {row_cell, col_cell};
  endfunction

endpackage

// File: rtl/trace_grid_recorder_if.sv
// Purpose: groups the cursor/control inputs and the trace result outputs of the recorder.
// Latency: n/a, wiring only.
// Backpressure: none; all signals are level or single-cycle pulses.
//
// Signals: frame_tick, cursor_row[8:0], cursor_col[9:0], start, clear   (towards recorder)
//          trace_mask[15:0], seq_out[63:0], seq_len[4:0], busy, done, timed_out (from recorder)
// Modports: master = cursor front end side, slave = recorder side.
interface trace_grid_recorder_if;
  import trace_pkg::*;

  logic                  frame_tick;
  logic [ROW_W-1:0]      cursor_row;
  logic [COL_W-1:0]      cursor_col;
  logic                  start;
  logic                  clear;

  logic [NUM_CELLS-1:0]  trace_mask;
  logic [SEQ_W-1:0]      seq_out;
  logic [SEQ_LEN_W-1:0]  seq_len;
  logic                  busy;
  logic                  done;
  logic                  timed_out;

  modport master (
    output frame_tick, cursor_row, cursor_col, start, clear,
    input  trace_mask, seq_out, seq_len, busy, done, timed_out
  );

  modport slave (
    input  frame_tick, cursor_row, cursor_col, start, clear,
    output trace_mask, seq_out, seq_len, busy, done, timed_out
  );

endinterface

// File: rtl/trace_grid_recorder_cell_locator.sv
// Purpose: maps a cursor pixel position onto a 4x4 grid cell index.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: i_cursor_row[8:0], i_cursor_col[9:0] -> o_cell_idx[3:0], o_cell_valid.
// Parameters: TRACE_ROW0, TRACE_COL0, CELL_SIZE (grid origin and cell edge in pixels).
module trace_cell_locator
  import trace_pkg::*;
#(
  parameter int TRACE_ROW0 = DEF_TRACE_ROW0,
  parameter int TRACE_COL0 = DEF_TRACE_COL0,
  parameter int CELL_SIZE  = DEF_CELL_SIZE
) (
  input  logic [ROW_W-1:0]      i_cursor_row,
  input  logic [COL_W-1:0]      i_cursor_col,
  output logic [CELL_IDX_W-1:0] o_cell_idx,
  output logic                  o_cell_valid
);

  // Wide enough for both cursor axes and the far edge of the trace area.
  localparam int CMP_W = 12;

  // Cell boundaries along each axis; the cell is found by comparing against
  // these constants instead of dividing.
  localparam logic [CMP_W-1:0] ROW_B0  = CMP_W'(TRACE_ROW0);
  localparam logic [CMP_W-1:0] ROW_B1  = CMP_W'(TRACE_ROW0 + CELL_SIZE);
  localparam logic [CMP_W-1:0] ROW_B2  = CMP_W'(TRACE_ROW0 + 2 * CELL_SIZE);
  localparam logic [CMP_W-1:0] ROW_B3  = CMP_W'(TRACE_ROW0 + 3 * CELL_SIZE);
  localparam logic [CMP_W-1:0] ROW_END = CMP_W'(TRACE_ROW0 + GRID_DIM * CELL_SIZE);

  localparam logic [CMP_W-1:0] COL_B0  = CMP_W'(TRACE_COL0);
  localparam logic [CMP_W-1:0] COL_B1  = CMP_W'(TRACE_COL0 + CELL_SIZE);
  localparam logic [CMP_W-1:0] COL_B2  = CMP_W'(TRACE_COL0 + 2 * CELL_SIZE);
  localparam logic [CMP_W-1:0] COL_B3  = CMP_W'(TRACE_COL0 + 3 * CELL_SIZE);
  localparam logic [CMP_W-1:0] COL_END = CMP_W'(TRACE_COL0 + GRID_DIM * CELL_SIZE);

  logic [CMP_W-1:0] w_row;
  logic [CMP_W-1:0] w_col;
  logic [1:0]       w_row_cell;
  logic [1:0]       w_col_cell;
  logic             w_row_in;
  logic             w_col_in;

  assign w_row = CMP_W'(i_cursor_row);
  assign w_col = CMP_W'(i_cursor_col);

  // Highest boundary passed wins. Positions before the first boundary fall
  // through to 0 but are flagged invalid below.
  always_comb begin
    w_row_cell = 2'd0;
    if (w_row >= ROW_B3) begin
      w_row_cell = 2'd3;
    end else if (w_row >= ROW_B2) begin
      w_row_cell = 2'd2;
    end else if (w_row >= ROW_B1) begin
      w_row_cell = 2'd1;
    end
  end

  always_comb begin
    w_col_cell = 2'd0;
    if (w_col >= COL_B3) begin
      w_col_cell = 2'd3;
    end else if (w_col >= COL_B2) begin
      w_col_cell = 2'd2;
    end else if (w_col >= COL_B1) begin
      w_col_cell = 2'd1;
    end
  end

  assign w_row_in     = (w_row >= ROW_B0) && (w_row < ROW_END);
  assign w_col_in     = (w_col >= COL_B0) && (w_col < COL_END);
  assign o_cell_valid = w_row_in && w_col_in;
  assign o_cell_idx   = cell_index(w_row_cell, w_col_cell);

endmodule

// File: rtl/trace_grid_recorder.sv
// Purpose: records which 4x4 grid cells the wand cursor dwelt in, and the order they were first visited.
// Latency: a registration on a frame_tick is visible on the outputs the next cycle; busy/done follow the same cycle.
// Backpressure: none; inputs are sampled only on frame_tick and never stalled.
//
// Ports: clk, reset (synchronous, active high), bus (trace_grid_recorder_if.slave):
//   in : frame_tick, cursor_row[8:0], cursor_col[9:0], start, clear
//   out: trace_mask[15:0] (feeds vga_controller.ir_in), seq_out[63:0], seq_len[4:0],
//        busy, done, timed_out
// Build option: define TRACE_SEQ_EN to store the visit order in seq_out; without it
//   seq_out reads 0 and no sequence storage exists. Everything else is identical.
module trace_grid_recorder
  import trace_pkg::*;
#(
  parameter int TRACE_ROW0     = DEF_TRACE_ROW0,
  parameter int TRACE_COL0     = DEF_TRACE_COL0,
  parameter int CELL_SIZE      = DEF_CELL_SIZE,
  parameter int DWELL_FRAMES   = DEF_DWELL_FRAMES,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset,
  trace_grid_recorder_if.slave  bus
);

  localparam int DWELL_W = $clog2(DWELL_FRAMES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [DWELL_W-1:0]   DWELL_MAX   = DWELL_W'(DWELL_FRAMES);
  localparam logic [TO_W-1:0]      TIMEOUT_MAX = TO_W'(TIMEOUT_FRAMES);
  localparam logic [SEQ_LEN_W-1:0] SEQ_FULL    = SEQ_LEN_W'(NUM_CELLS);

  // Current cursor cell.
  logic [CELL_IDX_W-1:0] w_cell_idx;
  logic                  w_cell_vld;

  // Architectural state and its next values.
  trace_state_e          r_state,     w_state_nxt;
  logic [NUM_CELLS-1:0]  r_mask,      w_mask_nxt;
  logic [SEQ_LEN_W-1:0]  r_seq_len,   w_seq_len_nxt;
  logic                  r_timed_out, w_timed_out_nxt;
  logic                  r_busy;
  logic                  r_done;

  // Dwell tracking: the cell seen on the previous tracing tick and how long
  // the cursor has stayed there.
  logic [DWELL_W-1:0]    r_dwell,     w_dwell_nxt;
  logic [CELL_IDX_W-1:0] r_prev_idx,  w_prev_idx_nxt;
  logic                  r_prev_vld,  w_prev_vld_nxt;

  // Frames since the last registration.
  logic [TO_W-1:0]       r_timeout,   w_timeout_nxt;

  // Per-tick candidate values, only committed on a tracing tick.
  logic                  w_tick;
  logic                  w_wipe;
  logic                  w_same;
  logic                  w_reg;
  logic [DWELL_W-1:0]    w_dwell_upd;
  logic [SEQ_LEN_W-1:0]  w_seq_len_upd;
  logic [TO_W-1:0]       w_timeout_upd;

  trace_cell_locator #(
    .TRACE_ROW0 (TRACE_ROW0),
    .TRACE_COL0 (TRACE_COL0),
    .CELL_SIZE  (CELL_SIZE)
  ) u_locator (
    .i_cursor_row (bus.cursor_row),
    .i_cursor_col (bus.cursor_col),
    .o_cell_idx   (w_cell_idx),
    .o_cell_valid (w_cell_vld)
  );

  // A frame tick sharing a cycle with start or clear is dropped, so a new
  // trace always begins its dwell count on the following tick.
  assign w_tick = bus.frame_tick && !bus.start && !bus.clear;

  // Clear always wipes; start wipes only when not already tracing.
  assign w_wipe = bus.clear || (bus.start && (r_state != TRACING));

  // Dwell, registration and timeout candidates for the current tick.
  always_comb begin
    w_same        = w_cell_vld && r_prev_vld && (w_cell_idx == r_prev_idx);
    w_dwell_upd   = '0;
    if (w_same) begin
      w_dwell_upd = (r_dwell == DWELL_MAX) ? DWELL_MAX : r_dwell + DWELL_W'(1);
    end else if (w_cell_vld) begin
      w_dwell_upd = DWELL_W'(1);
    end

    // A cell already in the mask never registers a second time.
    w_reg         = w_cell_vld && (w_dwell_upd == DWELL_MAX) && !r_mask[w_cell_idx];
    w_seq_len_upd = r_seq_len + SEQ_LEN_W'(w_reg);

    // The timeout only runs once the first cell is in, and saturates.
    w_timeout_upd = r_timeout;
    if (w_reg) begin
      w_timeout_upd = '0;
    end else if ((r_seq_len != '0) && (r_timeout != TIMEOUT_MAX)) begin
      w_timeout_upd = r_timeout + TO_W'(1);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt     = r_state;
    w_mask_nxt      = r_mask;
    w_seq_len_nxt   = r_seq_len;
    w_timed_out_nxt = r_timed_out;
    w_dwell_nxt     = r_dwell;
    w_prev_idx_nxt  = r_prev_idx;
    w_prev_vld_nxt  = r_prev_vld;
    w_timeout_nxt   = r_timeout;

    if (w_wipe) begin
      w_state_nxt     = bus.clear ? IDLE : TRACING;
      w_mask_nxt      = '0;
      w_seq_len_nxt   = '0;
      w_timed_out_nxt = 1'b0;
      w_dwell_nxt     = '0;
      w_prev_idx_nxt  = '0;
      w_prev_vld_nxt  = 1'b0;
      w_timeout_nxt   = '0;
    end else begin
      case (r_state)
        TRACING: begin
          if (w_tick) begin
            w_dwell_nxt    = w_dwell_upd;
            w_prev_idx_nxt = w_cell_idx;
            w_prev_vld_nxt = w_cell_vld;
            w_timeout_nxt  = w_timeout_upd;
            if (w_reg) begin
              w_mask_nxt    = r_mask | (NUM_CELLS'(1) << w_cell_idx);
              w_seq_len_nxt = w_seq_len_upd;
            end
            // A full grid ends the trace normally, even on the same tick the
            // timeout would otherwise expire.
            if (w_seq_len_upd == SEQ_FULL) begin
              w_state_nxt     = DONE;
              w_timed_out_nxt = 1'b0;
            end else if (w_timeout_upd == TIMEOUT_MAX) begin
              w_state_nxt     = DONE;
              w_timed_out_nxt = 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE only leave on start/clear, handled above.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_seq_len   <= '0;
      r_timed_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dwell     <= '0;
      r_prev_idx  <= '0;
      r_prev_vld  <= 1'b0;
      r_timeout   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mask      <= w_mask_nxt;
      r_seq_len   <= w_seq_len_nxt;
      r_timed_out <= w_timed_out_nxt;
      r_busy      <= (w_state_nxt == TRACING);
      r_done      <= (w_state_nxt == DONE);
      r_dwell     <= w_dwell_nxt;
      r_prev_idx  <= w_prev_idx_nxt;
      r_prev_vld  <= w_prev_vld_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

`ifdef TRACE_SEQ_EN
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] w_seq_nxt;

  // The registering cell goes into the nibble addressed by the count of
  // cells registered so far; seq_len is at most 15 while still tracing.
  always_comb begin
    w_seq_nxt = r_seq;
    if (w_wipe) begin
      w_seq_nxt = '0;
    end else if ((r_state == TRACING) && w_tick && w_reg) begin
      w_seq_nxt[{r_seq_len[3:0], 2'b00} +: CELL_IDX_W] = w_cell_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq <= '0;
    end else begin
      r_seq <= w_seq_nxt;
    end
  end

  assign bus.seq_out = r_seq;
`else
  assign bus.seq_out = '0;
`endif

  assign bus.trace_mask = r_mask;
  assign bus.seq_len    = r_seq_len;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.timed_out  = r_timed_out;

endmodule

// File: tb/tb_trace_grid_recorder.sv
// Purpose: self-checking bench for trace_grid_recorder: vector table, corner sequences, random vs model.
// Latency: each stimulus step is one clock; outputs are checked on the following falling edge.
// Backpressure: n/a.
module tb_trace_grid_recorder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trace_grid_recorder_if bus();

  trace_grid_recorder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state 0 idle, 1 tracing, 2 done.
  int          m_state;
  logic [15:0] m_mask;
  int          m_seq[$];
  int          m_dwell;
  int          m_prev;
  int          m_idle;
  logic        m_timed;

  typedef struct {
    logic        pre_wipe;
    int          row;
    int          col;
    int          n;
    logic [15:0] exp_mask;
    int          exp_len;
    logic [63:0] exp_seq;
  } vec_t;

  vec_t vt[15];

  function automatic int cell_of(input int r, input int c);
    if (r < 40 || r >= 440 || c < 120 || c >= 520) return -1;
    return ((r - 40) / 100) * 4 + (c - 120) / 100;
  endfunction

  function automatic int crow(input int c);
    return 90 + 100 * (c / 4);
  endfunction

  function automatic int ccol(input int c);
    return 170 + 100 * (c % 4);
  endfunction

  function automatic logic [63:0] seq_gate(input logic [63:0] v);
`ifdef TRACE_SEQ_EN
    return v;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] model_seq();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < m_seq.size(); k++) v[k*4 +: 4] = 4'(m_seq[k]);
    return seq_gate(v);
  endfunction

  task automatic model_wipe(input int st);
    m_state = st;
    m_mask  = '0;
    m_seq.delete();
    m_dwell = 0;
    m_prev  = -1;
    m_idle  = 0;
    m_timed = 1'b0;
  endtask

  task automatic model_step(input logic ft, input logic st, input logic cl, input logic rst,
                            input int row, input int col);
    int c;
    if (rst || cl) begin
      model_wipe(0);
    end else if (st && m_state != 1) begin
      model_wipe(1);
    end else if (ft && !st && m_state == 1) begin
      c = cell_of(row, col);
      if (c >= 0 && c == m_prev) begin
        if (m_dwell < 4) m_dwell++;
      end else begin
        m_dwell = (c >= 0) ? 1 : 0;
      end
      m_prev = c;
      if (c >= 0 && m_dwell == 4 && !m_mask[c]) begin
        m_mask[c] = 1'b1;
        m_seq.push_back(c);
        m_idle = 0;
      end else if (m_seq.size() > 0 && m_idle < 180) begin
        m_idle++;
      end
      if (m_seq.size() == 16) begin
        m_state = 2;
      end else if (m_idle == 180) begin
        m_state = 2;
        m_timed = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle from a falling edge; returns on the next falling edge
  // with pulses dropped and the registered result ready to check.
  task automatic drive(input logic ft, input logic st, input logic cl, input logic rst,
                       input int row, input int col);
    bus.frame_tick = ft;
    bus.start      = st;
    bus.clear      = cl;
    reset          = rst;
    bus.cursor_row = 9'(row);
    bus.cursor_col = 10'(col);
    model_step(ft, st, cl, rst, row, col);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic tick(input int row, input int col);
    drive(1'b1, 1'b0, 1'b0, 1'b0, row, col);
  endtask

  task automatic ticks(input int n, input int row, input int col);
    for (int k = 0; k < n; k++) tick(row, col);
  endtask

  task automatic restart();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mask"},  64'(bus.trace_mask), 64'd0);
    chk({tag, ".len"},   64'(bus.seq_len),    64'd0);
    chk({tag, ".seq"},   bus.seq_out,         64'd0);
    chk({tag, ".busy"},  64'(bus.busy),       64'd0);
    chk({tag, ".done"},  64'(bus.done),       64'd0);
    chk({tag, ".tmo"},   64'(bus.timed_out),  64'd0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".mask"}, 64'(bus.trace_mask), 64'(m_mask));
    chk({tag, ".len"},  64'(bus.seq_len),    64'(m_seq.size()));
    chk({tag, ".seq"},  bus.seq_out,         model_seq());
    chk({tag, ".busy"}, 64'(bus.busy),       64'(m_state == 1));
    chk({tag, ".done"}, 64'(bus.done),       64'(m_state == 2));
    chk({tag, ".tmo"},  64'(bus.timed_out),  64'(m_timed));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, row, col, cur_cell, cur_left;

    vt[0]  = '{1'b1,  90, 170, 3, 16'h0000, 0, 64'h0};
    vt[1]  = '{1'b0,  90, 170, 1, 16'h0001, 1, 64'h0};
    vt[2]  = '{1'b1, 190, 270, 4, 16'h0020, 1, 64'h5};
    vt[3]  = '{1'b0, 190, 370, 4, 16'h0060, 2, 64'h65};
    vt[4]  = '{1'b0, 190, 270, 4, 16'h0060, 2, 64'h65};
    vt[5]  = '{1'b0, 290, 370, 4, 16'h0460, 3, 64'hA65};
    vt[6]  = '{1'b1, 139, 219, 4, 16'h0001, 1, 64'h0};
    vt[7]  = '{1'b0, 140, 220, 4, 16'h0021, 2, 64'h50};
    vt[8]  = '{1'b0, 439, 519, 4, 16'h8021, 3, 64'hF50};
    vt[9]  = '{1'b0, 440, 519, 4, 16'h8021, 3, 64'hF50};
    vt[10] = '{1'b0,  39, 120, 4, 16'h8021, 3, 64'hF50};
    vt[11] = '{1'b0,  40, 520, 4, 16'h8021, 3, 64'hF50};
    vt[12] = '{1'b0,  40, 119, 4, 16'h8021, 3, 64'hF50};
    vt[13] = '{1'b0,  40, 120, 4, 16'h8021, 3, 64'hF50};
    vt[14] = '{1'b0, 340, 120, 4, 16'h9021, 4, 64'hCF50};

    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.cursor_row = '0;
    bus.cursor_col = '0;
    reset          = 1'b1;
    model_wipe(0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_zero("reset");

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      if (vt[i].pre_wipe) restart();
      ticks(vt[i].n, vt[i].row, vt[i].col);
      chk($sformatf("vec%0d.mask", i), 64'(bus.trace_mask), 64'(vt[i].exp_mask));
      chk($sformatf("vec%0d.len", i),  64'(bus.seq_len),    64'(vt[i].exp_len));
      chk($sformatf("vec%0d.seq", i),  bus.seq_out,         seq_gate(vt[i].exp_seq));
      chk($sformatf("vec%0d.busy", i), 64'(bus.busy),       64'd1);
    end

    // Alternating between cells 0 and 1 every 3 ticks never completes a dwell.
    restart();
    for (int k = 0; k < 30; k++) begin
      if ((k / 3) % 2 == 0) tick(90, 170);
      else                  tick(90, 270);
    end
    chk("alt.mask", 64'(bus.trace_mask), 64'd0);
    chk("alt.len",  64'(bus.seq_len),    64'd0);

    // A tick coinciding with start is discarded.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 90, 170);
    ticks(3, 90, 170);
    chk("stick.mask3", 64'(bus.trace_mask), 64'd0);
    tick(90, 170);
    chk("stick.mask4", 64'(bus.trace_mask), 64'd1);

    // Visit all 16 cells.
    restart();
    for (int c = 0; c < 16; c++) begin
      ticks(3, crow(c), ccol(c));
      if (c == 15) begin
        chk("all.len15",  64'(bus.seq_len), 64'd15);
        chk("all.busy15", 64'(bus.busy),    64'd1);
        chk("all.done15", 64'(bus.done),    64'd0);
      end
      tick(crow(c), ccol(c));
    end
    chk("all.done", 64'(bus.done),       64'd1);
    chk("all.busy", 64'(bus.busy),       64'd0);
    chk("all.tmo",  64'(bus.timed_out),  64'd0);
    chk("all.mask", 64'(bus.trace_mask), 64'hFFFF);
    chk("all.len",  64'(bus.seq_len),    64'd16);
    chk("all.seq",  bus.seq_out,         seq_gate(64'hFEDCBA9876543210));
    ticks(5, 90, 170);
    chk("all.post.mask", 64'(bus.trace_mask), 64'hFFFF);
    chk("all.post.len",  64'(bus.seq_len),    64'd16);
    chk("all.post.done", 64'(bus.done),       64'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 90, 170);
    chk("redo.busy", 64'(bus.busy),       64'd1);
    chk("redo.done", 64'(bus.done),       64'd0);
    chk("redo.mask", 64'(bus.trace_mask), 64'd0);

    // Timeout after one cell with the cursor outside the area.
    restart();
    ticks(4, 90, 170);
    ticks(179, 10, 170);
    chk("tmo.busy179", 64'(bus.busy), 64'd1);
    chk("tmo.done179", 64'(bus.done), 64'd0);
    tick(10, 170);
    chk("tmo.done", 64'(bus.done),       64'd1);
    chk("tmo.tmo",  64'(bus.timed_out),  64'd1);
    chk("tmo.mask", 64'(bus.trace_mask), 64'd1);
    chk("tmo.len",  64'(bus.seq_len),    64'd1);

    // Clear with start in the same cycle, then reset mid-trace.
    restart();
    ticks(4, 190, 270);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 190, 270);
    check_zero("clrstart");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 190, 270);
    ticks(4, 190, 270);
    chk("pre_rst.mask", 64'(bus.trace_mask), 64'h20);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 190, 270);
    check_zero("midreset");

    // Random stimulus against the model.
    cur_cell = 0;
    cur_left = 0;
    for (int s = 0; s < 600; s++) begin
      r = int'($urandom_range(0, 99));
      if (cur_left == 0) begin
        cur_cell = (int'($urandom_range(0, 99)) < 15) ? -1 : int'($urandom_range(0, 15));
        cur_left = int'($urandom_range(1, 7));
      end
      if (cur_cell < 0) begin
        row = int'($urandom_range(0, 39));
        col = int'($urandom_range(0, 1023));
      end else begin
        row = 40 + 100 * (cur_cell / 4) + int'($urandom_range(0, 99));
        col = 120 + 100 * (cur_cell % 4) + int'($urandom_range(0, 99));
      end
      if (r < 2) begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, row, col);
      end else if (r < 5) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, row, col);
      end else if (r < 10) begin
        drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, row, col);
      end else if (r < 16) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)));
      end else begin
        tick(row, col);
        cur_left--;
      end
      check_model($sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
